sort_job_scheduler: RTL and testbench
=====================================

Name: sort_job_scheduler

Overview:
- Shares one N-element sort engine among NREQ requesters.
- Latches a winning requester's operand vector and pulses the engine start.
- Waits for engine done, with a watchdog timeout, then returns the sorted vector on a valid/ready response channel tagged with the requester id.
- Arbitration is round-robin, one job in flight at a time.

Parameters:
- NREQ, 4, number of requesters (2..8)
- N, 6, elements per vector
- WIDTH, 8, bits per element
- TIMEOUT, 16, max cycles spent in WAIT before the job is aborted with error (>= 8)

Ports:
- clk  in  1  clock, all flops on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  per-requester job request
- req_ready  out  NREQ  per-requester accept, one-hot or zero
- req_data  in  NREQ*N*WIDTH  operand vectors; requester r occupies slice [r*N*WIDTH +: N*WIDTH]; element e is at [e*WIDTH +: WIDTH] within the slice
- rsp_valid  out  1  response available
- rsp_ready  in  1  response consumer accept
- rsp_id  out  $clog2(NREQ)  requester index of the response
- rsp_data  out  N*WIDTH  sorted vector, element 0 = smallest
- rsp_err  out  1  1 = job timed out; rsp_data is all zeros
- eng_start  out  1  one-cycle start pulse to the sort engine
- eng_data_in  out  N*WIDTH  operand to the engine, held stable from START through WAIT
- eng_done  in  1  one-cycle engine completion pulse
- eng_data_sorted  in  N*WIDTH  engine result, valid in the eng_done cycle
- busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async): state IDLE, rr_ptr=0, timer=0. All outputs 0: req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, eng_start, eng_data_in, busy.
  - Reset mid-job aborts silently; no response is emitted.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If any req_valid, grant g = first index with req_valid set, searching upward from rr_ptr with wrap modulo NREQ.
  - req_ready[g]=1 combinationally in that same cycle; this is the accept handshake.
  - At the clock edge: operand register <= req_data slice g, id register <= g, go to START.
  - If no req_valid: stay in IDLE; req_ready stays 0.
  - req_ready is 0 in every state except IDLE.
- START:
  - eng_start=1 (registered, exactly one cycle); timer <= 0; go to WAIT.
- WAIT:
  - If eng_done: rsp_data <= eng_data_sorted, rsp_err <= 0, go to RESP.
  - Else if timer == TIMEOUT-1: rsp_data <= 0, rsp_err <= 1, go to RESP.
  - Else timer <= timer+1.
  - eng_done and the timeout cycle coinciding: done wins, no error.
- RESP:
  - rsp_valid=1, and rsp_id/rsp_data/rsp_err stay stable until rsp_ready is sampled high.
  - On that cycle: rr_ptr <= (id+1) mod NREQ, rsp_valid <= 0, go to IDLE.
- eng_done outside WAIT is ignored. This covers a late done after a timeout and a spurious done.
- eng_data_in equals the operand register at all times; the register changes only on an IDLE grant edge.
- Latency with rsp_ready tied high and an engine done 6 cycles after start:
  - accept at cycle T, eng_start at T+1, eng_done at T+7, rsp_valid at T+8.
  - Next accept no earlier than T+9 (the cycle after the RESP handshake).
- Fairness: a requester holding req_valid is granted within NREQ jobs.
- Requesters must hold req_valid and req_data stable until req_ready; the block samples data only on the accept cycle.
- Element comparison and ordering are the engine's responsibility; the scheduler never alters data except zeroing it on error.

Test Plan:
- Single job: req_valid[2]=1, req_data[2]={5,3,9,1,7,2}; engine model returns {1,2,3,5,7,9} 6 cycles after start -> one eng_start pulse; rsp_valid with rsp_id=2, rsp_data={1,2,3,5,7,9}, rsp_err=0 at accept+8.
- Round-robin: all four req_valid held high for 8 jobs -> grant order 0,1,2,3,0,1,2,3; no requester is starved.
- Backpressure: rsp_ready held low for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_data stable throughout; req_ready=0 for all requesters; no new eng_start.
- Timeout: engine never asserts done -> rsp_err=1, rsp_data=0 exactly TIMEOUT cycles after WAIT entry; a late eng_done in RESP/IDLE is ignored and does not corrupt the next job.
- Boundary: eng_done arrives in the cycle where timer==TIMEOUT-1 -> rsp_err=0 and rsp_data = the engine result.
- Reset mid-job: assert rst during WAIT -> all outputs 0 immediately; rr_ptr=0; the first job after release is granted to the lowest valid index.

Source files
------------

// File: rtl/sort_job_scheduler.sv
// Round-robin front end that time-shares one N-element sort engine among NREQ
// requesters: one job in flight, watchdog on the engine, tagged valid/ready response.
module sort_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int N       = 6,
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*N*WIDTH-1:0]   req_data,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [N*WIDTH-1:0]        rsp_data,
  output logic                      rsp_err,
  output logic                      eng_start,
  output logic [N*WIDTH-1:0]        eng_data_in,
  input  logic                      eng_done,
  input  logic [N*WIDTH-1:0]        eng_data_sorted,
  output logic                      busy
);
  localparam int IDW = $clog2(NREQ);
  localparam int VW  = N*WIDTH;
  localparam int TW  = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

  state_t           r_state;
  logic [IDW-1:0]   r_rr_ptr;
  logic [IDW-1:0]   r_id;
  logic [TW-1:0]    r_timer;
  logic [VW-1:0]    r_op;
  logic [VW-1:0]    r_rsp_data;
  logic             r_rsp_valid;
  logic             r_rsp_err;
  logic             r_eng_start;
  logic             r_busy;

  logic             w_any;
  logic [IDW-1:0]   w_gnt_idx;
  int               w_k;

  // First valid requester at or above the round-robin pointer, wrapping.
  always_comb begin
    w_any     = 1'b0;
    w_gnt_idx = '0;
    w_k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      w_k = int'(r_rr_ptr) + i;
      if (w_k >= NREQ) w_k = w_k - NREQ;
      if (!w_any && req_valid[IDW'(w_k)]) begin
        w_any     = 1'b1;
        w_gnt_idx = IDW'(w_k);
      end
    end
  end

  // Accept is combinational so the requester sees its handshake in the grant cycle.
  assign req_ready   = (r_state == S_IDLE && w_any && !rst) ? (NREQ'(1) << w_gnt_idx) : '0;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_id      = r_id;
  assign rsp_data    = r_rsp_data;
  assign rsp_err     = r_rsp_err;
  assign eng_start   = r_eng_start;
  assign eng_data_in = r_op;
  assign busy        = r_busy;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_timer     <= '0;
      r_op        <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_eng_start <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_eng_start <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_op        <= req_data[w_gnt_idx*VW +: VW];
            r_id        <= w_gnt_idx;
            r_eng_start <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_START;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          // A done landing on the last watchdog cycle still counts as success.
          if (eng_done) begin
            r_rsp_data  <= eng_data_sorted;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else if (r_timer == TW'(TIMEOUT-1)) begin
            r_rsp_data  <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rr_ptr    <= (r_id == IDW'(NREQ-1)) ? '0 : r_id + 1'b1;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_job_scheduler.sv
// Bench for sort_job_scheduler: behavioural engine, round-robin grant model and
// sorted-result reference, with randomized requests and engine latencies.
module tb_sort_job_scheduler;
  localparam int NREQ = 4, N = 6, WIDTH = 8, TIMEOUT = 16;
  localparam int IDW = $clog2(NREQ), VW = N*WIDTH;

  logic                 clk = 1'b0, rst;
  logic [NREQ-1:0]      req_valid, req_ready;
  logic [NREQ*VW-1:0]   req_data;
  logic                 rsp_valid, rsp_ready, rsp_err, eng_start, eng_done, busy;
  logic [IDW-1:0]       rsp_id;
  logic [VW-1:0]        rsp_data, eng_data_in, eng_sorted;
  int n_cmp = 0, n_bad = 0, n_start = 0, eng_delay = 6, m_rr = 0;

  sort_job_scheduler #(.NREQ(NREQ), .N(N), .WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_err(rsp_err), .eng_start(eng_start), .eng_data_in(eng_data_in), .eng_done(eng_done),
    .eng_data_sorted(eng_sorted), .busy(busy));

  always #5 clk = ~clk;
  always @(posedge clk) if (eng_start === 1'b1) n_start++;

  function automatic logic [VW-1:0] sort_vec(input logic [VW-1:0] x);
    int a[N]; int t; logic [VW-1:0] y;
    for (int e = 0; e < N; e++) a[e] = int'(x[e*WIDTH +: WIDTH]);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N-1-i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    y = '0;
    for (int e = 0; e < N; e++) y[e*WIDTH +: WIDTH] = WIDTH'(a[e]);
    return y;
  endfunction

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] y;
    for (int e = 0; e < N; e++) y[e*WIDTH +: WIDTH] = WIDTH'($urandom);
    return y;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] v, input int rr);
    for (int k = 0; k < NREQ; k++) if (v[(rr+k)%NREQ]) return (rr+k)%NREQ;
    return 0;
  endfunction

  // Behavioural engine: done eng_delay cycles after the start cycle; 0 = never.
  initial begin
    eng_done = 1'b0; eng_sorted = '0;
    forever begin
      @(posedge clk);
      if (eng_start === 1'b1 && rst === 1'b0 && eng_delay > 0) begin
        repeat (eng_delay-1) @(posedge clk);
        #1 eng_done = 1'b1; eng_sorted = sort_vec(eng_data_in);
        @(posedge clk); #1 eng_done = 1'b0; eng_sorted = '0;
      end
    end
  end

  task automatic tick(); @(posedge clk); #1; endtask

  task automatic issue(input logic [NREQ-1:0] v, output logic [NREQ-1:0] rdy, output bit to);
    to = 1'b1; rdy = '0; req_valid = v;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (|req_ready) begin rdy = req_ready; to = 1'b0; break; end
      tick();
    end
    tick();
    req_valid = v & ~rdy;
  endtask

  task automatic wait_rsp(output int cyc, output bit to);
    cyc = 1; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (rsp_valid === 1'b1) begin to = 1'b0; break; end
      tick(); cyc++;
    end
  endtask

  task automatic run_job(input logic [NREQ-1:0] v, input int dly, output logic [NREQ-1:0] rdy,
                         output int cyc, output bit to, output logic [IDW-1:0] id,
                         output logic [VW-1:0] data, output logic err, output int starts);
    int s0; bit t1, t2;
    s0 = n_start; eng_delay = dly;
    issue(v, rdy, t1);
    wait_rsp(cyc, t2);
    to = t1 | t2; id = rsp_id; data = rsp_data; err = rsp_err;
    tick();
    starts = n_start - s0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 4'b0101; rsp_ready = 1'b1; req_data = '1;
    tick(); tick();
    n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", req_ready); end
    n_cmp++; if ({rsp_valid, rsp_err, eng_start, busy} !== 4'b0) begin n_bad++;
      $display("FAIL reset_flags: got %b want 0000", {rsp_valid, rsp_err, eng_start, busy}); end
    n_cmp++; if ({rsp_id, rsp_data, eng_data_in} !== '0) begin n_bad++;
      $display("FAIL reset_data: got id=%0d rsp=%h eng=%h want zeros", rsp_id, rsp_data, eng_data_in); end
    req_valid = '0; req_data = '0; rst = 1'b0; m_rr = 0;
    tick();
  endtask

  task automatic test_single();
    logic [NREQ-1:0] rdy; int cyc, st; bit to; logic [IDW-1:0] id; logic [VW-1:0] d; logic err;
    logic [VW-1:0] exp_d;
    exp_d = {8'd9, 8'd7, 8'd5, 8'd3, 8'd2, 8'd1};
    req_data[2*VW +: VW] = {8'd2, 8'd7, 8'd1, 8'd9, 8'd3, 8'd5};
    run_job(4'b0100, 6, rdy, cyc, to, id, d, err, st);
    n_cmp++; if (to) begin n_bad++; $display("FAIL single_timeout: got timeout want response"); end
    n_cmp++; if (rdy !== 4'b0100) begin n_bad++; $display("FAIL single_ready: got %b want 0100", rdy); end
    n_cmp++; if (cyc != 8) begin n_bad++; $display("FAIL single_latency: got %0d want 8", cyc); end
    n_cmp++; if (id !== 2'd2) begin n_bad++; $display("FAIL single_id: got %0d want 2", id); end
    n_cmp++; if (d !== exp_d) begin n_bad++; $display("FAIL single_data: got %h want %h", d, exp_d); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL single_err: got %b want 0", err); end
    n_cmp++; if (st != 1) begin n_bad++; $display("FAIL single_starts: got %0d want 1", st); end
    n_cmp++; if ({rsp_valid, busy} !== 2'b00) begin n_bad++;
      $display("FAIL single_idle: got valid/busy %b want 00", {rsp_valid, busy}); end
    m_rr = 3;
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] rdy, erdy; int cyc, st, g, dly; bit to; logic [IDW-1:0] id;
    logic [VW-1:0] d, ev; logic err;
    rst = 1'b1; tick(); rst = 1'b0; m_rr = 0;
    for (int r = 0; r < NREQ; r++) req_data[r*VW +: VW] = rand_vec();
    for (int j = 0; j < 2*NREQ; j++) begin
      g = model_grant('1, m_rr); erdy = '0; erdy[g] = 1'b1;
      ev = sort_vec(req_data[g*VW +: VW]); dly = $urandom_range(1, 10);
      run_job('1, dly, rdy, cyc, to, id, d, err, st);
      n_cmp++; if (to || rdy !== erdy) begin n_bad++; $display("FAIL rr_ready[%0d]: got %b want %b", j, rdy, erdy); end
      n_cmp++; if (id !== IDW'(j % NREQ)) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", j, id, j % NREQ); end
      n_cmp++; if (d !== ev || err !== 1'b0) begin n_bad++;
        $display("FAIL rr_data[%0d]: got %h err=%b want %h err=0", j, d, err, ev); end
      n_cmp++; if (cyc != dly+2) begin n_bad++; $display("FAIL rr_latency[%0d]: got %0d want %0d", j, cyc, dly+2); end
      m_rr = (g+1) % NREQ;
      req_data[g*VW +: VW] = rand_vec();
    end
    req_valid = '0;
  endtask

  task automatic test_random();
    logic [NREQ-1:0] rdy, erdy, pend, nw; int cyc, st, g, dly; int age[NREQ]; bit to;
    logic [IDW-1:0] id; logic [VW-1:0] d, ev; logic err;
    pend = '0;
    for (int r = 0; r < NREQ; r++) age[r] = 0;
    for (int j = 0; j < 20; j++) begin
      nw = NREQ'($urandom) & ~pend;
      if ((pend | nw) == '0) nw[$urandom_range(0, NREQ-1)] = 1'b1;
      for (int r = 0; r < NREQ; r++) if (nw[r]) begin req_data[r*VW +: VW] = rand_vec(); age[r] = 0; end
      pend = pend | nw;
      g = model_grant(pend, m_rr); erdy = '0; erdy[g] = 1'b1;
      ev = sort_vec(req_data[g*VW +: VW]); dly = $urandom_range(1, TIMEOUT);
      run_job(pend, dly, rdy, cyc, to, id, d, err, st);
      n_cmp++; if (to || rdy !== erdy || id !== IDW'(g)) begin n_bad++;
        $display("FAIL rand_grant[%0d]: got rdy=%b id=%0d want rdy=%b id=%0d", j, rdy, id, erdy, g); end
      n_cmp++; if (d !== ev || err !== 1'b0 || cyc != dly+2 || st != 1) begin n_bad++;
        $display("FAIL rand_rsp[%0d]: got %h err=%b lat=%0d st=%0d want %h err=0 lat=%0d st=1",
                 j, d, err, cyc, st, ev, dly+2); end
      n_cmp++; if (age[id] > NREQ-1) begin n_bad++; $display("FAIL rand_fair[%0d]: got wait %0d want <= %0d", j, age[id], NREQ-1); end
      for (int r = 0; r < NREQ; r++) if (pend[r] && r != int'(id)) age[r]++;
      pend[g] = 1'b0; m_rr = (g+1) % NREQ;
    end
    req_valid = '0;
  endtask

  task automatic test_back_pressure();
    logic [NREQ-1:0] rdy; int cyc, s0, g; bit t1, t2; logic [VW-1:0] op, ev;
    g = model_grant(4'b0010, m_rr);
    req_data[g*VW +: VW] = rand_vec(); op = req_data[g*VW +: VW]; ev = sort_vec(op);
    eng_delay = 3; s0 = n_start; rsp_ready = 1'b0;
    issue(4'b0010, rdy, t1);
    wait_rsp(cyc, t2);
    n_cmp++; if (t1 || t2 || rdy !== 4'b0010) begin n_bad++; $display("FAIL bp_accept: got rdy=%b to=%b want 0010", rdy, t1|t2); end
    req_valid = 4'b1101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++; if (rsp_valid !== 1'b1 || rsp_id !== IDW'(g)) begin n_bad++;
        $display("FAIL bp_hold[%0d]: got valid=%b id=%0d want 1/%0d", i, rsp_valid, rsp_id, g); end
      n_cmp++; if (rsp_data !== ev || rsp_err !== 1'b0) begin n_bad++;
        $display("FAIL bp_data[%0d]: got %h want %h", i, rsp_data, ev); end
      n_cmp++; if (req_ready !== '0) begin n_bad++; $display("FAIL bp_ready[%0d]: got %b want 0", i, req_ready); end
      n_cmp++; if (n_start - s0 != 1 || eng_data_in !== op) begin n_bad++;
        $display("FAIL bp_engine[%0d]: got starts=%0d op=%h want 1/%h", i, n_start - s0, eng_data_in, op); end
    end
    req_valid = '0; rsp_ready = 1'b1;
    tick();
    n_cmp++; if (rsp_valid !== 1'b0) begin n_bad++; $display("FAIL bp_release: got %b want 0", rsp_valid); end
    m_rr = (g+1) % NREQ;
  endtask

  task automatic test_timeout();
    logic [NREQ-1:0] rdy; int cyc, st, s0, g; bit to, t1; logic [IDW-1:0] id; logic [VW-1:0] d, ev; logic err;
    g = model_grant(4'b0001, m_rr);
    eng_delay = 0; s0 = n_start; rsp_ready = 1'b0;
    issue(4'b0001, rdy, t1);
    wait_rsp(cyc, to);
    n_cmp++; if (t1 || to || cyc != TIMEOUT+2) begin n_bad++; $display("FAIL to_latency: got %0d want %0d", cyc, TIMEOUT+2); end
    n_cmp++; if (rsp_err !== 1'b1 || rsp_data !== '0 || rsp_id !== IDW'(g)) begin n_bad++;
      $display("FAIL to_rsp: got err=%b data=%h id=%0d want 1/0/%0d", rsp_err, rsp_data, rsp_id, g); end
    eng_done = 1'b1; eng_sorted = rand_vec(); tick(); eng_done = 1'b0;
    n_cmp++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_data !== '0) begin n_bad++;
      $display("FAIL to_late_done: got valid=%b err=%b data=%h want 1/1/0", rsp_valid, rsp_err, rsp_data); end
    rsp_ready = 1'b1; tick(); m_rr = (g+1) % NREQ;
    eng_done = 1'b1; eng_sorted = rand_vec(); tick(); eng_done = 1'b0; tick();
    n_cmp++; if ({rsp_valid, busy} !== 2'b00 || n_start - s0 != 1) begin n_bad++;
      $display("FAIL to_spurious: got valid/busy=%b starts=%0d want 00/1", {rsp_valid, busy}, n_start - s0); end
    g = model_grant(4'b0100, m_rr);
    req_data[g*VW +: VW] = rand_vec(); ev = sort_vec(req_data[g*VW +: VW]);
    run_job(4'b0100, 4, rdy, cyc, to, id, d, err, st);
    n_cmp++; if (to || d !== ev || err !== 1'b0 || cyc != 6 || st != 1) begin n_bad++;
      $display("FAIL to_next_job: got %h err=%b lat=%0d st=%0d want %h/0/6/1", d, err, cyc, st, ev); end
    m_rr = (g+1) % NREQ;
  endtask

  task automatic test_boundary();
    logic [NREQ-1:0] rdy; int cyc, st, g; bit to; logic [IDW-1:0] id; logic [VW-1:0] d, ev; logic err;
    g = model_grant(4'b1000, m_rr);
    req_data[g*VW +: VW] = rand_vec(); ev = sort_vec(req_data[g*VW +: VW]);
    run_job(4'b1000, TIMEOUT, rdy, cyc, to, id, d, err, st);
    n_cmp++; if (to || err !== 1'b0 || d !== ev || cyc != TIMEOUT+2) begin n_bad++;
      $display("FAIL edge_done_wins: got err=%b %h lat=%0d want 0 %h lat=%0d", err, d, cyc, ev, TIMEOUT+2); end
    m_rr = (g+1) % NREQ;
    g = model_grant(4'b0001, m_rr);
    run_job(4'b0001, TIMEOUT+1, rdy, cyc, to, id, d, err, st);
    n_cmp++; if (to || err !== 1'b1 || d !== '0 || cyc != TIMEOUT+2) begin n_bad++;
      $display("FAIL edge_one_late: got err=%b %h lat=%0d want 1 0 lat=%0d", err, d, cyc, TIMEOUT+2); end
    m_rr = (g+1) % NREQ;
    g = model_grant(4'b0010, m_rr);
    req_data[g*VW +: VW] = rand_vec(); ev = sort_vec(req_data[g*VW +: VW]);
    run_job(4'b0010, 2, rdy, cyc, to, id, d, err, st);
    n_cmp++; if (to || err !== 1'b0 || d !== ev || id !== IDW'(g) || st != 1) begin n_bad++;
      $display("FAIL edge_after_late: got id=%0d err=%b %h want %0d 0 %h", id, err, d, g, ev); end
    m_rr = (g+1) % NREQ;
  endtask

  task automatic test_reset_mid_job();
    logic [NREQ-1:0] rdy; int cyc, st, g; bit to, t1; logic [IDW-1:0] id; logic [VW-1:0] d, ev; logic err;
    eng_delay = 0; req_data[2*VW +: VW] = rand_vec();
    issue(4'b0100, rdy, t1);
    req_valid = 4'b1010;
    repeat (3) tick();
    n_cmp++; if (t1 || busy !== 1'b1) begin n_bad++; $display("FAIL mid_busy: got %b want 1", busy); end
    rst = 1'b1; #1;
    n_cmp++; if (req_ready !== '0 || {rsp_valid, rsp_err, eng_start, busy} !== 4'b0) begin n_bad++;
      $display("FAIL mid_reset_flags: got rdy=%b flags=%b want 0", req_ready, {rsp_valid, rsp_err, eng_start, busy}); end
    n_cmp++; if ({rsp_id, rsp_data, eng_data_in} !== '0) begin n_bad++;
      $display("FAIL mid_reset_data: got id=%0d rsp=%h eng=%h want zeros", rsp_id, rsp_data, eng_data_in); end
    tick(); rst = 1'b0; m_rr = 0;
    g = model_grant(4'b1010, m_rr);
    req_data[g*VW +: VW] = rand_vec(); ev = sort_vec(req_data[g*VW +: VW]);
    run_job(4'b1010, 5, rdy, cyc, to, id, d, err, st);
    n_cmp++; if (to || rdy !== 4'b0010 || id !== 2'd1) begin n_bad++;
      $display("FAIL mid_first_grant: got rdy=%b id=%0d want 0010/1", rdy, id); end
    n_cmp++; if (d !== ev || err !== 1'b0 || cyc != 7) begin n_bad++;
      $display("FAIL mid_first_rsp: got %h err=%b lat=%0d want %h/0/7", d, err, cyc, ev); end
    req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_random();
    test_back_pressure();
    test_timeout();
    test_boundary();
    test_reset_mid_job();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish want finish");
    $fatal(1, "bench time limit");
  end

endmodule
